ones_run_monitor: RTL and testbench

- Statistics stage directly downstream of the consecutive-ones detector.
- Observes the same serial bit `a` that the detector samples, together with the detector's output `y` (here `det`).
- Tracks:
  - the live length of the current run of ones;
  - the longest completed run;
  - the number of completed runs that were qualified, i.e. the detector fired at least once during the run.
- Software/test logic reads a coherent snapshot of the statistics through a 4-phase req/ack handshake.

---
 rtl/ones_mon_pkg.sv | 18 +
 rtl/ones_run_tracker.sv | 85 ++++++++
 rtl/ones_run_monitor.sv | 108 ++++++++++
 tb/tb_ones_run_monitor.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/ones_mon_pkg.sv
// Shared types and default widths for the consecutive-ones run statistics block.
package ones_mon_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    SAT
  } run_state_t;

  typedef enum logic {
    R_IDLE,
    R_ACK
  } rd_state_t;

  localparam int CW_DEF = 8;
  localparam int EW_DEF = 8;

endpackage

// File: rtl/ones_run_tracker.sv
// Run FSM: follows the current run of ones, its saturating length and whether the
// detector fired during it; flags the cycle in which the run ends.
module ones_run_tracker
  import ones_mon_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a,
  input  logic          det,
  output logic [CW-1:0] run_len,
  output logic          run_end,
  output logic          qual_at_end,
  output logic [CW-1:0] final_len
);

  localparam logic [CW-1:0] LEN_MAX = '1;
  localparam logic [CW-1:0] LEN_ONE = CW'(1);

  run_state_t    r_state;
  run_state_t    w_state_nxt;
  logic [CW-1:0] r_run_len;
  logic [CW-1:0] w_len_nxt;
  logic          r_qual;
  logic          w_qual_nxt;
  logic          w_run_end;

  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt   = r_run_len;
    w_qual_nxt  = r_qual;
    w_run_end   = 1'b0;
    case (r_state)
      IDLE: begin
        if (a) begin
          w_len_nxt   = LEN_ONE;
          w_state_nxt = (LEN_ONE == LEN_MAX) ? SAT : RUN;
        end
      end
      RUN: begin
        if (a) begin
          w_len_nxt = r_run_len + LEN_ONE;
          if (w_len_nxt == LEN_MAX) w_state_nxt = SAT;
        end else begin
          w_run_end   = 1'b1;
          w_len_nxt   = '0;
          w_state_nxt = IDLE;
        end
      end
      SAT: begin
        if (!a) begin
          w_run_end   = 1'b1;
          w_len_nxt   = '0;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_len_nxt   = '0;
        w_state_nxt = IDLE;
      end
    endcase
    // det is only meaningful while a=1; a run end always drops the flag
    if (w_run_end) w_qual_nxt = 1'b0;
    else if (a && det) w_qual_nxt = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_run_len <= '0;
      r_qual    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_run_len <= w_len_nxt;
      r_qual    <= w_qual_nxt;
    end
  end

  assign run_len     = r_run_len;
  assign run_end     = w_run_end;
  assign qual_at_end = r_qual;
  assign final_len   = r_run_len;

endmodule

// File: rtl/ones_run_monitor.sv
// Run statistics behind the consecutive-ones detector: longest run, qualified-run
// count with sticky overflow, and a req/ack snapshot port for software.
module ones_run_monitor
  import ones_mon_pkg::*;
#(
  parameter int CW = CW_DEF,
  parameter int EW = EW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a,
  input  logic          det,
  input  logic          clr,
  input  logic          rd_req,
  output logic          rd_ack,
  output logic [CW-1:0] run_len,
  output logic [EW-1:0] snap_events,
  output logic [CW-1:0] snap_max,
  output logic          ovf
);

  localparam logic [EW-1:0] EV_MAX = '1;
  localparam logic [EW-1:0] EV_ONE = EW'(1);

  function automatic logic [EW-1:0] ev_sat_inc(input logic [EW-1:0] v);
    return (v == EV_MAX) ? v : v + EV_ONE;
  endfunction

  logic          w_run_end;
  logic          w_qual_at_end;
  logic [CW-1:0] w_final_len;

  logic [EW-1:0] r_event_cnt;
  logic [CW-1:0] r_max_run;
  logic          r_ovf;
  logic [EW-1:0] r_snap_events;
  logic [CW-1:0] r_snap_max;
  rd_state_t     r_rd_state;
  rd_state_t     w_rd_nxt;
  logic          w_capture;

  ones_run_tracker #(
    .CW(CW)
  ) u_tracker (
    .clk        (clk),
    .rst        (rst),
    .a          (a),
    .det        (det),
    .run_len    (run_len),
    .run_end    (w_run_end),
    .qual_at_end(w_qual_at_end),
    .final_len  (w_final_len)
  );

  // clr outranks a coincident run end, so that run leaves no trace
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_event_cnt <= '0;
      r_max_run   <= '0;
      r_ovf       <= 1'b0;
    end else if (clr) begin
      r_event_cnt <= '0;
      r_max_run   <= '0;
      r_ovf       <= 1'b0;
    end else if (w_run_end) begin
      if (w_final_len > r_max_run) r_max_run <= w_final_len;
      if (w_qual_at_end) begin
        if (r_event_cnt == EV_MAX) r_ovf <= 1'b1;
        r_event_cnt <= ev_sat_inc(r_event_cnt);
      end
    end
  end

  always_comb begin
    w_rd_nxt  = r_rd_state;
    w_capture = 1'b0;
    case (r_rd_state)
      R_IDLE: begin
        if (rd_req) begin
          w_capture = 1'b1;
          w_rd_nxt  = R_ACK;
        end
      end
      R_ACK:   if (!rd_req) w_rd_nxt = R_IDLE;
      default: w_rd_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_state    <= R_IDLE;
      r_snap_events <= '0;
      r_snap_max    <= '0;
    end else begin
      r_rd_state <= w_rd_nxt;
      if (w_capture) begin
        r_snap_events <= r_event_cnt;
        r_snap_max    <= r_max_run;
      end
    end
  end

  assign rd_ack      = (r_rd_state == R_ACK);
  assign snap_events = r_snap_events;
  assign snap_max    = r_snap_max;
  assign ovf         = r_ovf;

endmodule

// File: tb/tb_ones_run_monitor.sv
// Directed bench for ones_run_monitor built with CW=4, EW=2 so both saturation
// limits are reachable with short vectors.
module tb_ones_run_monitor;

  localparam int CW = 4;
  localparam int EW = 2;

  logic          clk;
  logic          rst;
  logic          a;
  logic          det;
  logic          clr;
  logic          rd_req;
  logic          rd_ack;
  logic [CW-1:0] run_len;
  logic [EW-1:0] snap_events;
  logic [CW-1:0] snap_max;
  logic          ovf;

  int n_assert = 0;
  int n_fail   = 0;

  ones_run_monitor #(
    .CW(CW),
    .EW(EW)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .a          (a),
    .det        (det),
    .clr        (clr),
    .rd_req     (rd_req),
    .rd_ack     (rd_ack),
    .run_len    (run_len),
    .snap_events(snap_events),
    .snap_max   (snap_max),
    .ovf        (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_run_len"}, 32'(run_len), 0);
    check_val({tag, "_rd_ack"}, 32'(rd_ack), 0);
    check_val({tag, "_snap_events"}, 32'(snap_events), 0);
    check_val({tag, "_snap_max"}, 32'(snap_max), 0);
    check_val({tag, "_ovf"}, 32'(ovf), 0);
  endtask

  task automatic do_read(input string tag, input int exp_ev, input int exp_max);
    rd_req = 1'b1;
    step();
    check_val({tag, "_ack_hi"}, 32'(rd_ack), 1);
    check_val({tag, "_events"}, 32'(snap_events), exp_ev);
    check_val({tag, "_max"}, 32'(snap_max), exp_max);
    rd_req = 1'b0;
    step();
    check_val({tag, "_ack_lo"}, 32'(rd_ack), 0);
  endtask

  // one-cycle qualified run: det with a=1 on its only one
  task automatic short_qual_run();
    a = 1'b1; det = 1'b1;
    step();
    a = 1'b0; det = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b0; a = 1'b0; det = 1'b0; clr = 1'b0; rd_req = 1'b0;
    #1;
    check_all_zero("reset_init");
    step();
    step();
    rst = 1'b1;

    // reset asserted mid-run and mid-handshake
    a = 1'b1; rd_req = 1'b1;
    step();
    check_val("pre_rst_len1", 32'(run_len), 1);
    step();
    step();
    check_val("pre_rst_len3", 32'(run_len), 3);
    check_val("pre_rst_ack", 32'(rd_ack), 1);
    #3 rst = 1'b0;
    #1;
    check_all_zero("rst_async");
    step();
    check_all_zero("rst_hold1");
    step();
    check_all_zero("rst_hold2");
    a = 1'b0; rd_req = 1'b0; rst = 1'b1;
    step();
    do_read("rd_after_rst", 0, 0);

    // short unqualified run
    a = 1'b1; step(); check_val("unq_len1", 32'(run_len), 1);
    a = 1'b1; step(); check_val("unq_len2", 32'(run_len), 2);
    a = 1'b0; step(); check_val("unq_len0", 32'(run_len), 0);
    do_read("rd_unq", 0, 2);

    // qualified run, det on 3rd and 4th ones
    a = 1'b1; det = 1'b0; step(); check_val("q_len1", 32'(run_len), 1);
    a = 1'b1; det = 1'b0; step(); check_val("q_len2", 32'(run_len), 2);
    a = 1'b1; det = 1'b1; step(); check_val("q_len3", 32'(run_len), 3);
    a = 1'b1; det = 1'b1; step(); check_val("q_len4", 32'(run_len), 4);
    a = 1'b0; det = 1'b0; step(); check_val("q_len0", 32'(run_len), 0);
    do_read("rd_qual", 1, 4);

    // det with a=0 must not qualify the next run
    det = 1'b1; step();
    det = 1'b0; a = 1'b1; step();
    a = 1'b0; step();
    do_read("rd_det_a0", 1, 4);

    // run-length saturation at 15
    for (int i = 1; i <= 20; i++) begin
      a = 1'b1;
      step();
      check_val($sformatf("sat_len_c%0d", i), 32'(run_len), (i < 15) ? i : 15);
    end
    a = 1'b0; step(); check_val("sat_len_end", 32'(run_len), 0);
    do_read("rd_sat", 1, 15);

    // event-counter saturation and sticky ovf
    clr = 1'b1; step(); clr = 1'b0;
    check_val("clr_ovf", 32'(ovf), 0);
    do_read("rd_clr1", 0, 0);
    for (int k = 1; k <= 5; k++) begin
      short_qual_run();
      check_val($sformatf("ovf_run%0d", k), 32'(ovf), (k >= 4) ? 1 : 0);
    end
    do_read("rd_evsat", 3, 1);
    clr = 1'b1; step(); clr = 1'b0;
    check_val("clr2_ovf", 32'(ovf), 0);
    do_read("rd_clr2", 0, 0);

    // rd_req held 4 cycles, rising on the edge where a qualified run ends
    a = 1'b1; det = 1'b1; step();
    a = 1'b1; det = 1'b0; step();
    a = 1'b0; rd_req = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      step();
      check_val($sformatf("hs_ack_c%0d", c), 32'(rd_ack), 1);
      check_val($sformatf("hs_ev_c%0d", c), 32'(snap_events), 0);
      check_val($sformatf("hs_max_c%0d", c), 32'(snap_max), 0);
    end
    rd_req = 1'b0;
    step();
    check_val("hs_ack_fall", 32'(rd_ack), 0);
    do_read("rd_after_hs", 1, 2);

    // clr on the run-end edge discards that run
    a = 1'b1; det = 1'b1; step();
    a = 1'b0; det = 1'b0; clr = 1'b1; step();
    clr = 1'b0;
    do_read("rd_clr_coll", 0, 0);

    // clr mid-run leaves the run in progress to be counted
    a = 1'b1; det = 1'b1; step();
    a = 1'b1; det = 1'b0; clr = 1'b1; step();
    check_val("clr_mid_len", 32'(run_len), 2);
    clr = 1'b0; a = 1'b0; step();
    do_read("rd_clr_mid", 1, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
